// File: rtl/rgmii_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_pkg
// Brief    : Shared types, widths and helpers for the RGMII TX arbiter.
// Revision : 1.0
// ============================================================================
package rgmii_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_e;

    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgmii_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_rr_pick
// Brief    : Combinational round-robin picker (rotate, priority-encode, rotate back).
// Revision : 1.0
// ============================================================================
module rgmii_rr_pick
    import rgmii_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_i,
    output logic [IDX_W-1:0] next_o,
    output logic             any_req_o
);

    localparam logic [IDX_W:0] c_N = (IDX_W+1)'(N_REQ);

    logic [IDX_W-1:0] w_start;
    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_ofs;
    logic [IDX_W:0]   w_sum;

    assign w_start = (({1'b0, last_i} + 1'b1) >= c_N) ? '0 : (last_i + 1'b1);

    // Position 0 of the rotated vector is the requester just after the last grant
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = int'(w_start) + i;
            if (idx >= N_REQ) idx = idx - N_REQ;
            w_rot[i] = req_i[idx];
        end
    end

    always_comb begin
        w_ofs = '0;
        for (int i = N_REQ-1; i >= 0; i--) begin
            if (w_rot[i]) w_ofs = IDX_W'(i);
        end
    end

    assign w_sum     = {1'b0, w_start} + {1'b0, w_ofs};
    assign next_o    = (w_sum >= c_N) ? IDX_W'(w_sum - c_N) : w_sum[IDX_W-1:0];
    assign any_req_o = |req_i;

endmodule
`default_nettype wire

// File: rtl/rgmii_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rgmii_tx_arbiter
// Brief    : Frame-atomic round-robin arbiter feeding the RGMII MAC TX stream.
// Revision : 1.0
// ============================================================================
module rgmii_tx_arbiter
    import rgmii_pkg::*;
#(
    parameter int N_REQ           = 4,
    parameter int MAX_FRAME_BYTES = 1518,
    parameter int CNT_W           = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [N_REQ*BYTE_W-1:0] s_tdata,
    input  logic [N_REQ-1:0]        s_tvalid,
    input  logic [N_REQ-1:0]        s_tlast,
    input  logic [N_REQ-1:0]        s_tuser,
    output logic [N_REQ-1:0]        s_tready,
    output logic [BYTE_W-1:0]       m_tdata,
    output logic                    m_tvalid,
    output logic                    m_tlast,
    output logic                    m_tuser,
    input  logic                    m_tready,
    output logic [2:0]              grant_idx,
    output logic                    busy,
    output logic                    trunc_pulse,
    output logic [15:0]             frame_cnt
);

    localparam int               IDX_W      = clog2_min1(N_REQ);
    localparam logic [CNT_W-1:0] c_LIMIT    = CNT_W'(MAX_FRAME_BYTES-1);
    localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(N_REQ-1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               trunc_q, trunc_d;
    logic               busy_q;

    logic [IDX_W-1:0]   w_pick;
    logic               w_any;
    logic [BYTE_W-1:0]  w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_sel_user;
    logic               w_at_limit;
    logic               w_accept;

    rgmii_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i     (s_tvalid),
        .last_i    (grant_q),
        .next_o    (w_pick),
        .any_req_o (w_any)
    );

    assign w_sel_data  = s_tdata[int'(grant_q)*BYTE_W +: BYTE_W];
    assign w_sel_valid = s_tvalid[grant_q];
    assign w_sel_last  = s_tlast[grant_q];
    assign w_sel_user  = s_tuser[grant_q];
    assign w_at_limit  = (cnt_q == c_LIMIT);
    assign w_accept    = m_tvalid & m_tready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= c_LAST_IDX;
            cnt_q       <= '0;
            frame_cnt_q <= '0;
            trunc_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            frame_cnt_q <= frame_cnt_d;
            trunc_q     <= trunc_d;
            busy_q      <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        frame_cnt_d = frame_cnt_q;
        trunc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && w_any) begin
                    grant_d = w_pick;
                    cnt_d   = '0;
                    state_d = PASS;
                end
            end
            PASS: begin
                if (w_accept) begin
                    cnt_d = cnt_q + 1'b1;
                    // A real tlast on the limit beat ends the frame cleanly
                    if (w_sel_last) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        state_d     = IDLE;
                    end else if (w_at_limit) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                        trunc_d     = 1'b1;
                        state_d     = DROP;
                    end
                end
            end
            DROP: begin
                if (w_sel_valid && w_sel_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tuser  = 1'b0;
        s_tready = '0;
        case (state_q)
            PASS: begin
                m_tdata           = w_sel_data;
                m_tvalid          = w_sel_valid;
                m_tlast           = w_sel_last | w_at_limit;
                m_tuser           = w_sel_user | (w_at_limit & ~w_sel_last);
                s_tready[grant_q] = m_tready;
            end
            DROP: begin
                s_tready[grant_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_idx   = 3'(grant_q);
    assign busy        = busy_q;
    assign trunc_pulse = trunc_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rgmii_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_rgmii_tx_arbiter
// Brief    : Directed self-checking bench for rgmii_tx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rgmii_tx_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 1518;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [N*8-1:0] s_tdata;
    logic [N-1:0]   s_tvalid, s_tlast, s_tuser, s_tready;
    logic [7:0]     m_tdata;
    logic           m_tvalid, m_tlast, m_tuser, m_tready;
    logic [2:0]     grant_idx;
    logic           busy, trunc_pulse;
    logic [15:0]    frame_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    // Source model: each requester streams src_frames frames of src_len bytes
    int src_len[N], src_pos[N], src_frames[N], src_done[N];
    bit src_user[N];

    logic [N-1:0] o_ready, o_valid, o_last;
    logic [7:0]   o_data;
    logic         o_mv, o_ml, o_mu, o_mready, o_busy, o_trunc;
    logic [2:0]   o_grant;
    logic [15:0]  o_fc;

    always #4 clk = ~clk;

    rgmii_tx_arbiter #(.N_REQ(N), .MAX_FRAME_BYTES(MAXB), .CNT_W(14)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
        .m_tready(m_tready),
        .grant_idx(grant_idx), .busy(busy), .trunc_pulse(trunc_pulse), .frame_cnt(frame_cnt)
    );

    task automatic drive_srcs();
        for (int r = 0; r < N; r++) begin
            s_tvalid[r]        = (src_frames[r] > 0);
            s_tdata[r*8 +: 8]  = 8'(r*64 + src_pos[r]);
            s_tlast[r]         = (src_pos[r] == src_len[r]-1);
            s_tuser[r]         = src_user[r];
        end
    endtask

    task automatic cycle();
        drive_srcs();
        @(negedge clk);
        o_ready = s_tready; o_valid = s_tvalid; o_last = s_tlast;
        o_data = m_tdata; o_mv = m_tvalid; o_ml = m_tlast; o_mu = m_tuser;
        o_mready = m_tready; o_busy = busy; o_trunc = trunc_pulse;
        o_grant = grant_idx; o_fc = frame_cnt;
        @(posedge clk);
        #1;
        for (int r = 0; r < N; r++) begin
            if (o_valid[r] && o_ready[r]) begin
                if (o_last[r]) begin
                    src_pos[r] = 0; src_frames[r]--; src_done[r]++;
                end else begin
                    src_pos[r]++;
                end
            end
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1; enable = 1'b1; m_tready = 1'b1;
        for (int r = 0; r < N; r++) begin
            src_len[r] = 1; src_pos[r] = 0; src_frames[r] = 0; src_done[r] = 0; src_user[r] = 1'b0;
        end
        drive_srcs();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        cycle();
        tests_run++; if (o_mv !== 1'b0) begin tests_failed++; $display("FAIL reset_m_tvalid: got %b expected 0", o_mv); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        tests_run++; if (o_grant !== 3'd3) begin tests_failed++; $display("FAIL reset_grant: got %0d expected 3", o_grant); end
        tests_run++; if (o_fc !== 16'd0) begin tests_failed++; $display("FAIL reset_frame_cnt: got %0d expected 0", o_fc); end
        tests_run++; if (o_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_s_tready: got %b expected 0000", o_ready); end
        tests_run++; if (o_trunc !== 1'b0) begin tests_failed++; $display("FAIL reset_trunc: got %b expected 0", o_trunc); end
        tests_run++; if ({o_data, o_ml, o_mu} !== 10'd0) begin tests_failed++; $display("FAIL reset_m_data: got %h expected 0", {o_data, o_ml, o_mu}); end
    endtask

    task automatic test_single_frame();
        int beats, first, bad;
        beats = 0; first = -1; bad = 0;
        reset_dut();
        src_len[0] = 64; src_frames[0] = 1;
        for (int i = 0; i < 200 && src_done[0] == 0; i++) begin
            cycle();
            if (o_mv && o_mready) begin
                if (first < 0) first = i;
                if (o_data !== 8'(beats) || o_ml !== (beats == 63) || o_mu !== 1'b0) bad++;
                beats++;
            end
        end
        cycle();
        tests_run++; if (first != 1) begin tests_failed++; $display("FAIL single_latency: got cycle %0d expected 1", first); end
        tests_run++; if (beats != 64) begin tests_failed++; $display("FAIL single_beats: got %0d expected 64", beats); end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL single_data: got %0d bad beats expected 0", bad); end
        tests_run++; if (o_fc !== 16'd1) begin tests_failed++; $display("FAIL single_frame_cnt: got %0d expected 1", o_fc); end
        tests_run++; if (o_grant !== 3'd0) begin tests_failed++; $display("FAIL single_grant: got %0d expected 0", o_grant); end
        tests_run++; if (o_busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_end: got %b expected 0", o_busy); end
    endtask

    task automatic test_round_robin();
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        int fr, bt, er, bad_grant, bad_data, bad_user;
        fr = 0; bt = 0; bad_grant = 0; bad_data = 0; bad_user = 0;
        reset_dut();
        src_len[0] = 10; src_frames[0] = 2;
        src_len[1] = 10; src_frames[1] = 2;
        src_len[3] = 10; src_frames[3] = 2; src_user[3] = 1'b1;
        for (int i = 0; i < 400 && fr < 6; i++) begin
            cycle();
            if (o_mv && o_mready) begin
                er = exp_order[fr];
                if (o_ready !== N'(1 << er) || o_grant !== 3'(er)) bad_grant++;
                if (o_data !== 8'(er*64 + bt) || o_ml !== (bt == 9)) bad_data++;
                if (o_mu !== (er == 3)) bad_user++;
                bt++;
                if (bt == 10) begin bt = 0; fr++; end
            end
        end
        cycle();
        tests_run++; if (fr != 6) begin tests_failed++; $display("FAIL rr_frames: got %0d expected 6", fr); end
        tests_run++; if (bad_grant != 0) begin tests_failed++; $display("FAIL rr_order: got %0d bad beats expected 0", bad_grant); end
        tests_run++; if (bad_data != 0) begin tests_failed++; $display("FAIL rr_data: got %0d bad beats expected 0", bad_data); end
        tests_run++; if (bad_user != 0) begin tests_failed++; $display("FAIL rr_tuser: got %0d bad beats expected 0", bad_user); end
        tests_run++; if (o_fc !== 16'd6) begin tests_failed++; $display("FAIL rr_frame_cnt: got %0d expected 6", o_fc); end
    endtask

    task automatic test_truncation();
        int pass_b, drop_b, bad, pulses, pulse_cyc, trunc_cyc, early0, beats0;
        pass_b = 0; drop_b = 0; bad = 0; pulses = 0; pulse_cyc = -1; trunc_cyc = -1; early0 = 0; beats0 = 0;
        reset_dut();
        src_len[2] = 2000; src_frames[2] = 1;
        for (int i = 0; i < 3000 && src_done[0] == 0; i++) begin
            if (src_pos[2] == 1600 && src_frames[0] == 0 && src_done[0] == 0) begin
                src_len[0] = 10; src_frames[0] = 1;
            end
            cycle();
            if (o_trunc) begin pulses++; pulse_cyc = i; end
            if (o_mv && o_mready && o_ready[2]) begin
                if (o_data !== 8'(128 + pass_b) || o_ml !== (pass_b == MAXB-1) || o_mu !== (pass_b == MAXB-1)) bad++;
                if (pass_b == MAXB-1) trunc_cyc = i;
                pass_b++;
            end
            if (!o_mv && o_valid[2] && o_ready[2]) drop_b++;
            if (o_mv && o_ready[0]) begin
                if (src_done[2] == 0) early0++;
                beats0++;
            end
        end
        cycle();
        tests_run++; if (pass_b != MAXB) begin tests_failed++; $display("FAIL trunc_pass_beats: got %0d expected %0d", pass_b, MAXB); end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL trunc_data_flags: got %0d bad beats expected 0", bad); end
        tests_run++; if (drop_b != 482) begin tests_failed++; $display("FAIL trunc_drop_beats: got %0d expected 482", drop_b); end
        tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL trunc_pulse_count: got %0d expected 1", pulses); end
        tests_run++; if (pulse_cyc != trunc_cyc + 1) begin tests_failed++; $display("FAIL trunc_pulse_timing: got cycle %0d expected %0d", pulse_cyc, trunc_cyc + 1); end
        tests_run++; if (early0 != 0 || beats0 != 10) begin tests_failed++; $display("FAIL trunc_next_grant: got early=%0d beats=%0d expected early=0 beats=10", early0, beats0); end
        tests_run++; if (o_fc !== 16'd2) begin tests_failed++; $display("FAIL trunc_frame_cnt: got %0d expected 2", o_fc); end
    endtask

    task automatic test_exact_max();
        int beats, bad, pulses;
        beats = 0; bad = 0; pulses = 0;
        reset_dut();
        src_len[1] = MAXB; src_frames[1] = 1;
        for (int i = 0; i < 2000 && src_done[1] == 0; i++) begin
            cycle();
            if (o_trunc) pulses++;
            if (o_mv && o_mready) begin
                if (o_data !== 8'(64 + beats) || o_ml !== (beats == MAXB-1) || o_mu !== 1'b0) bad++;
                beats++;
            end
        end
        cycle();
        if (o_trunc) pulses++;
        tests_run++; if (beats != MAXB) begin tests_failed++; $display("FAIL exact_beats: got %0d expected %0d", beats, MAXB); end
        tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL exact_flags: got %0d bad beats expected 0", bad); end
        tests_run++; if (pulses != 0) begin tests_failed++; $display("FAIL exact_no_trunc: got %0d pulses expected 0", pulses); end
        tests_run++; if (o_fc !== 16'd1) begin tests_failed++; $display("FAIL exact_frame_cnt: got %0d expected 1", o_fc); end
    endtask

    task automatic test_backpressure();
        int beats, bad_data, bad_hold, bad_mirror;
        logic       p_stall;
        logic [7:0] p_data;
        logic       p_last;
        beats = 0; bad_data = 0; bad_hold = 0; bad_mirror = 0; p_stall = 1'b0; p_data = '0; p_last = 1'b0;
        reset_dut();
        src_len[0] = 20; src_frames[0] = 1;
        for (int i = 0; i < 200 && src_done[0] == 0; i++) begin
            m_tready = (i % 3 == 0);
            cycle();
            if (o_busy && (o_ready[0] !== o_mready || o_ready[N-1:1] !== '0)) bad_mirror++;
            if (p_stall && (o_mv !== 1'b1 || o_data !== p_data || o_ml !== p_last)) bad_hold++;
            if (o_mv && o_mready) begin
                if (o_data !== 8'(beats) || o_ml !== (beats == 19)) bad_data++;
                beats++;
            end
            p_stall = o_mv && !o_mready; p_data = o_data; p_last = o_ml;
        end
        m_tready = 1'b1;
        cycle();
        tests_run++; if (beats != 20) begin tests_failed++; $display("FAIL bp_beats: got %0d expected 20", beats); end
        tests_run++; if (bad_data != 0) begin tests_failed++; $display("FAIL bp_order: got %0d bad beats expected 0", bad_data); end
        tests_run++; if (bad_hold != 0) begin tests_failed++; $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad_hold); end
        tests_run++; if (bad_mirror != 0) begin tests_failed++; $display("FAIL bp_ready_mirror: got %0d bad cycles expected 0", bad_mirror); end
        tests_run++; if (o_fc !== 16'd1) begin tests_failed++; $display("FAIL bp_frame_cnt: got %0d expected 1", o_fc); end
    endtask

    task automatic test_enable();
        int beats, bad, bad_idle, waited;
        beats = 0; bad = 0; bad_idle = 0; waited = -1;
        reset_dut();
        src_len[0] = 16; src_frames[0] = 2;
        src_len[1] = 16; src_frames[1] = 1;
        for (int i = 0; i < 100 && src_done[0] == 0; i++) begin
            if (beats == 5) enable = 1'b0;
            cycle();
            if (o_mv && o_mready) begin
                if (o_data !== 8'(beats) || !o_ready[0]) bad++;
                beats++;
            end
        end
        tests_run++; if (beats != 16 || bad != 0) begin tests_failed++; $display("FAIL en_frame_completes: got beats=%0d bad=%0d expected beats=16 bad=0", beats, bad); end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_mv || o_busy) bad_idle++;
        end
        tests_run++; if (bad_idle != 0) begin tests_failed++; $display("FAIL en_no_grant: got %0d active cycles expected 0", bad_idle); end
        enable = 1'b1;
        for (int i = 0; i < 10 && waited < 0; i++) begin
            cycle();
            if (o_mv) waited = i;
        end
        tests_run++; if (waited < 0 || o_grant !== 3'd1 || o_ready !== 4'b0010) begin tests_failed++; $display("FAIL en_regrant: got grant=%0d ready=%b expected grant=1 ready=0010", o_grant, o_ready); end
    endtask

    task automatic test_reset_midframe();
        int beats, seen;
        beats = 0; seen = 0;
        reset_dut();
        src_len[0] = 64; src_frames[0] = 1;
        for (int i = 0; i < 100 && beats < 30; i++) begin
            cycle();
            if (o_mv && o_mready) beats++;
        end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (m_tvalid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_outputs: got tvalid=%b busy=%b expected 0 0", m_tvalid, busy); end
        tests_run++; if (s_tready !== 4'b0000) begin tests_failed++; $display("FAIL midrst_s_tready: got %b expected 0000", s_tready); end
        tests_run++; if (grant_idx !== 3'd3 || frame_cnt !== 16'd0) begin tests_failed++; $display("FAIL midrst_regs: got grant=%0d fc=%0d expected 3 0", grant_idx, frame_cnt); end
        src_pos[0] = 0; src_len[0] = 8; src_frames[0] = 1;
        src_len[1] = 8; src_frames[1] = 1;
        @(posedge clk);
        #2 rst = 1'b0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            cycle();
            if (o_mv) seen = 1;
        end
        tests_run++; if (seen == 0 || o_grant !== 3'd0 || o_ready !== 4'b0001) begin tests_failed++; $display("FAIL midrst_first_grant: got grant=%0d ready=%b expected grant=0 ready=0001", o_grant, o_ready); end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; m_tready = 1'b1;
        s_tdata = '0; s_tvalid = '0; s_tlast = '0; s_tuser = '0;
        test_reset();
        test_single_frame();
        test_round_robin();
        test_truncation();
        test_exact_max();
        test_backpressure();
        test_enable();
        test_reset_midframe();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
